fxp_seq_alu: RTL and testbench
==============================

Name: fxp_seq_alu

Overview:
- Handshaked, multi-cycle fixed-point ALU responder for 16-bit sign-magnitude Q8.8 operands: bit15 = sign, [14:8] = integer, [7:0] = fraction.
- Accepts one operation per valid/ready transaction and returns result plus flags on a separate valid/ready channel.
- Add/sub complete in one execute cycle; multiply uses an iterative shift-add over the magnitude bits.
- Sits between the operand sequencer and the writeback path, replacing the combinational fixed-point ALU wherever timing or area requires it.

Parameters:
- W, 16, total word width (sign + magnitude).
- FRAC, 8, fraction bits; multiply product is shifted right by FRAC.

Ports:
- clk  input  1  clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand/op valid
- in_ready  output  1  block can accept; high only in IDLE
- a  input  W  operand A, sign-magnitude
- b  input  W  operand B, sign-magnitude
- alu_control  input  3  000 add, 001 sub (a-b), 010 mul; others = NOP
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- res  output  W  result, sign-magnitude
- flags  output  4  [3]=N, [2]=Z, [1]=C, [0]=V

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; out_valid=0; res=0; flags=0; in_ready=1.
  - In-flight operation is abandoned; no partial result is ever presented.
- FSM states: IDLE, EXEC, MUL, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register a, b, alu_control.
  - Mul goes to MUL with iteration counter=W-2; all other ops go to EXEC.
- EXEC (1 cycle): compute add/sub/NOP into res/flags, then go to DONE.
- MUL:
  - Shift-add of |a|·|b|, one multiplier bit per cycle, W-1 cycles (15 for default W); counter decrements.
  - At counter=0, go to NORM.
- NORM (1 cycle): scale and saturate the product, then go to DONE.
- DONE:
  - out_valid=1; res/flags held stable.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
- Latency from accept edge to out_valid rise:
  - add/sub/NOP: 2 edges (EXEC, then DONE).
  - mul: W+1 edges (17 for default W).
- No overlap: in_ready=0 from accept until the DONE handshake completes. A new op is accepted no earlier than the cycle after out_valid&&out_ready.
- Add/sub:
  - Sub inverts b's sign bit, then uses the add path.
  - Equal signs: magnitudes are added.
    - Carry out of bit W-2 → magnitude saturates to all ones (0x7FFF), sign kept, C=1, V=1.
  - Differing signs: larger magnitude minus smaller; sign of the larger.
    - Equal magnitudes give +0.
- Mul:
  - Raw magnitude product is 2(W-1) bits; result magnitude = product >> FRAC.
  - If any bit above the W-1 result bits is set → saturate 0x7FFF, V=1, C=1.
  - Sign = sa^sb.
- Zero handling:
  - Input -0 (0x8000) is treated as +0.
  - Any zero result is forced to sign 0, with Z=1, N=0.
- Flags: N = result sign bit after zero forcing; Z = magnitude==0; C and V only as stated above, otherwise 0.
- NOP opcodes: res=0x0000, flags Z=1; uses the EXEC timing.
- in_valid while busy: ignored, no effect; the source must hold it until in_ready.

Optional Feature:
- Macro: FXP_ROUND_EN.
  - Defined: mul rounds to nearest by adding product bit FRAC-1 before the shift. A rounding carry that pushes the result out of range saturates as above.
  - Undefined: mul truncates toward zero.
- Add/sub are unaffected either way.

Test Plan:
- add 0x0320 (3.125) + 0x80C0 (-0.75) → res 0x0260, flags 0000; out_valid 2 edges after accept.
- add 0x8060 (-0.375) + 0x80C0 (-0.75) → res 0x8120, flags 1000. Sub 0x0180 - 0x0180 → res 0x0000, flags 0100.
- mul 0x80C0 × 0x0090 → res 0x806C, flags 1000, out_valid 17 edges after accept. Mul 0x80C0 × 0x8100 → 0x00C0.
- Saturation:
  - add 0x6400 + 0x3200 → res 0x7FFF, flags 0011.
  - mul 0x1000 × 0x1000 → res 0x7FFF, flags 0011.
- Rounding: mul 0x0001 × 0x0080.
  - Without FXP_ROUND_EN → 0x0000, flags 0100.
  - With FXP_ROUND_EN → 0x0001, flags 0000.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles in DONE → res/flags stable, in_ready=0, extra in_valid ignored.
  - Assert rst_n=0 mid-MUL → out_valid=0, res=0, in_ready=1 immediately.
  - After release, the next add completes correctly.

Source files
------------

// File: rtl/fxp_seq_alu.sv
// Handshaked multi-cycle sign-magnitude Q(W-1-FRAC).FRAC ALU: add/sub in one EXEC cycle, shift-add multiply over W-1 cycles.
// Define FXP_ROUND_EN for round-to-nearest on multiply; undefined truncates toward zero.
module fxp_seq_alu #(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   alu_control,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic [3:0]   flags
);

  localparam int M  = W - 1;
  localparam int PW = 2 * M;
  localparam int CW = $clog2(W);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_NORM, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [2:0]      r_op;
  logic            r_sa;
  logic            r_sb;
  logic [M-1:0]    r_ma;
  logic [M-1:0]    r_mb;
  logic [PW-1:0]   r_prod;
  logic [PW-1:0]   r_mcand;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_res;
  logic [3:0]      r_flags;

  logic            w_sb_eff;
  logic [M:0]      w_sum;
  logic [PW:0]     w_scaled;
  logic            w_sign;
  logic [M-1:0]    w_mag;
  logic            w_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = (alu_control == OP_MUL) ? S_MUL : S_EXEC;
      end
      S_EXEC: w_next = S_DONE;
      S_MUL:  if (r_cnt == '0) w_next = S_NORM;
      S_NORM: w_next = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Result path shared by EXEC (add/sub/NOP) and NORM (multiply scaling).
  always_comb begin
    w_sb_eff = r_sb ^ (r_op == OP_SUB);
    w_sum    = {1'b0, r_ma} + {1'b0, r_mb};
    w_scaled = {1'b0, r_prod} >> FRAC;
`ifdef FXP_ROUND_EN
    w_scaled = w_scaled + {{PW{1'b0}}, r_prod[FRAC-1]};
`endif
    w_sign = 1'b0;
    w_mag  = '0;
    w_sat  = 1'b0;
    if (r_state == S_NORM) begin
      w_sign = r_sa ^ r_sb;
      if (|w_scaled[PW:M]) begin
        w_mag = '1;
        w_sat = 1'b1;
      end else begin
        w_mag = w_scaled[M-1:0];
      end
    end else if (r_op == OP_ADD || r_op == OP_SUB) begin
      if (r_sa == w_sb_eff) begin
        w_sign = r_sa;
        if (w_sum[M]) begin
          w_mag = '1;
          w_sat = 1'b1;
        end else begin
          w_mag = w_sum[M-1:0];
        end
      end else if (r_ma >= r_mb) begin
        w_sign = r_sa;
        w_mag  = r_ma - r_mb;
      end else begin
        w_sign = w_sb_eff;
        w_mag  = r_mb - r_ma;
      end
    end
    if (w_mag == '0) w_sign = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_ma    <= '0;
      r_mb    <= '0;
      r_prod  <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_flags <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          // Negative zero is folded to +0 at capture.
          r_op    <= alu_control;
          r_sa    <= a[W-1] & (|a[M-1:0]);
          r_sb    <= b[W-1] & (|b[M-1:0]);
          r_ma    <= a[M-1:0];
          r_mb    <= b[M-1:0];
          r_prod  <= '0;
          r_mcand <= {{M{1'b0}}, a[M-1:0]};
          r_cnt   <= CW'(W - 2);
        end
        S_MUL: begin
          if (r_mb[0]) r_prod <= r_prod + r_mcand;
          r_mcand <= r_mcand << 1;
          r_mb    <= r_mb >> 1;
          r_cnt   <= r_cnt - CW'(1);
        end
        S_EXEC, S_NORM: begin
          r_res   <= {w_sign, w_mag};
          r_flags <= {w_sign, (w_mag == '0), w_sat, w_sat};
        end
        default: ;
      endcase
    end
  end

  assign res   = r_res;
  assign flags = r_flags;

endmodule

// File: tb/tb_fxp_seq_alu.sv
// Bench for fxp_seq_alu: directed cases plus random ops against an integer-arithmetic reference model.
module tb_fxp_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [2:0]  alu_control = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] res;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  fxp_seq_alu #(.W(16), .FRAC(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_control(alu_control), .out_valid(out_valid),
    .out_ready(out_ready), .res(res), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: operands as signed integers, result saturated to +/-32767.
  function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y, input logic [2:0] op);
    int ma, mb, va, vb, s, mag, p;
    logic sg, c;
    ma = int'(x[14:0]);
    mb = int'(y[14:0]);
    va = x[15] ? -ma : ma;
    vb = y[15] ? -mb : mb;
    c = 1'b0;
    sg = 1'b0;
    mag = 0;
    if (op == 3'd0 || op == 3'd1) begin
      s = (op == 3'd0) ? va + vb : va - vb;
      sg = (s < 0);
      mag = (s < 0) ? -s : s;
    end else if (op == 3'd2) begin
      p = ma * mb;
      mag = p / 256;
`ifdef FXP_ROUND_EN
      mag = mag + ((p / 128) % 2);
`endif
      sg = x[15] ^ y[15];
    end
    if (mag > 32767) begin
      mag = 32767;
      c = 1'b1;
    end
    if (mag == 0) sg = 1'b0;
    model = {sg, (mag == 0), c, c, sg, mag[14:0]};
  endfunction

  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_b,
                        input logic [2:0] op, input logic [15:0] exp_res, input logic [3:0] exp_flags);
    int lat;
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    a = ta; b = tb_b; alu_control = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), (op == 3'd2) ? 32'd17 : 32'd2);
    chk({tag, ".res"}, 32'(res), 32'(exp_res));
    chk({tag, ".flags"}, 32'(flags), 32'(exp_flags));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [19:0] e;
    logic [15:0] ra, rb, held_res;
    logic [3:0]  held_flags;
    logic [2:0]  rop;
    int lat;

    #12;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.res", 32'(res), 32'd0);
    chk("rst.flags", 32'(flags), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_mixed", 16'h0320, 16'h80C0, 3'd0, 16'h0260, 4'b0000);
    run_op("add_neg",   16'h8060, 16'h80C0, 3'd0, 16'h8120, 4'b1000);
    run_op("sub_eq",    16'h0180, 16'h0180, 3'd1, 16'h0000, 4'b0100);
    run_op("mul_neg",   16'h80C0, 16'h0090, 3'd2, 16'h806C, 4'b1000);
    run_op("mul_pos",   16'h80C0, 16'h8100, 3'd2, 16'h00C0, 4'b0000);
    run_op("add_sat",   16'h6400, 16'h3200, 3'd0, 16'h7FFF, 4'b0011);
    run_op("mul_sat",   16'h1000, 16'h1000, 3'd2, 16'h7FFF, 4'b0011);
    run_op("neg_zero",  16'h8000, 16'h0000, 3'd0, 16'h0000, 4'b0100);
    run_op("nop",       16'h1234, 16'h4321, 3'd5, 16'h0000, 4'b0100);
`ifdef FXP_ROUND_EN
    run_op("mul_round", 16'h0001, 16'h0080, 3'd2, 16'h0001, 4'b0000);
`else
    run_op("mul_round", 16'h0001, 16'h0080, 3'd2, 16'h0000, 4'b0100);
`endif

    // Hold the result in DONE while a stray request is presented.
    @(negedge clk);
    a = 16'h0100; b = 16'h0200; alu_control = 3'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    held_res = res;
    held_flags = flags;
    chk("hold.res0", 32'(held_res), 32'h0300);
    a = 16'h7000; b = 16'h7000; alu_control = 3'd2; in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold.out_valid", 32'(out_valid), 32'd1);
      chk("hold.in_ready", 32'(in_ready), 32'd0);
      chk("hold.res", 32'(res), 32'h0300);
      chk("hold.flags", 32'(flags), 32'h0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hold.release_ready", 32'(in_ready), 32'd1);
    chk("hold.release_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    a = 16'h0200; b = 16'h0300; alu_control = 3'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst.busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.res", 32'(res), 32'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst_add", 16'h0140, 16'h0040, 3'd0, 16'h0180, 4'b0000);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      if (rop > 3'd4) rop = 3'($urandom_range(0, 2));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        ra[14:0] = 15'($urandom_range(0, 16'h0FFF));
        rb[14:0] = 15'($urandom_range(0, 16'h0FFF));
      end
      if ($urandom_range(0, 9) == 0) ra = 16'h8000;
      e = model(ra, rb, rop);
      run_op("random", ra, rb, rop, e[15:0], e[19:16]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
